// File: rtl/noc_out_arbiter_if.sv
// Bundle of the per-port source signals and the packetizer-facing outputs of
// the NoC output arbiter.
//   master : arbiter side (drives src_busy and the noc_* outputs)
//   slave  : environment side (drives src_* and packetizer_busy)
// Per-port vectors pack port k at [k*W +: W].
interface noc_out_arbiter_if #(
  parameter int NUM_PORTS    = 2,
  parameter int MSG_BITS     = 4,
  parameter int ADDRESS_BITS = 32,
  parameter int L2_WIDTH     = 128,
  parameter int ID_BITS      = 2
);
  localparam int SRC_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS*MSG_BITS-1:0]     src_msg;
  logic [NUM_PORTS*ADDRESS_BITS-1:0] src_address;
  logic [NUM_PORTS*L2_WIDTH-1:0]     src_data;
  logic [NUM_PORTS*ID_BITS-1:0]      src_dest_id;
  logic [NUM_PORTS-1:0]              src_busy;
  logic                              packetizer_busy;
  logic [MSG_BITS-1:0]               noc_msg_out;
  logic [ADDRESS_BITS-1:0]           noc_address_out;
  logic [L2_WIDTH-1:0]               noc_data_out;
  logic [ID_BITS-1:0]                noc_dest_id;
  logic [SRC_W-1:0]                  noc_src_port;

  modport master (
    input  src_msg, src_address, src_data, src_dest_id, packetizer_busy,
    output src_busy, noc_msg_out, noc_address_out, noc_data_out, noc_dest_id,
           noc_src_port
  );

  modport slave (
    output src_msg, src_address, src_data, src_dest_id, packetizer_busy,
    input  src_busy, noc_msg_out, noc_address_out, noc_data_out, noc_dest_id,
           noc_src_port
  );
endinterface

// File: rtl/noc_out_arbiter.sv
// NoC output arbiter: NUM_PORTS cache-hierarchy sources share one packetizer.
// Each port owns a single hold slot; full slots are granted round-robin into
// an output register that is presented until the packetizer accepts it.
// Ports:
//   clock      - rising-edge clock
//   reset      - synchronous, active-low
//   bus        - noc_out_arbiter_if.master (src_* in, src_busy out,
//                packetizer_busy in, noc_* out, noc_src_port out)
//   ovf_error  - only with NOC_ARB_OVF_CHECK_EN defined: sticky per-port flag
//                set when a port sends while its slot is still full
module noc_out_arbiter #(
  parameter int NUM_PORTS    = 2,
  parameter int MSG_BITS     = 4,
  parameter int ADDRESS_BITS = 32,
  parameter int L2_WIDTH     = 128,
  parameter int ID_BITS      = 2
) (
  input logic clock,
  input logic reset,
  noc_out_arbiter_if.master bus
`ifdef NOC_ARB_OVF_CHECK_EN
  ,
  output logic [NUM_PORTS-1:0] ovf_error
`endif
);
  localparam int SRC_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {EMPTY, PRESENT} state_e;

  state_e                   state_q, state_d;
  logic [NUM_PORTS-1:0]     slot_full_q, slot_full_d;
  logic [SRC_W-1:0]         last_grant_q, last_grant_d;

  logic [MSG_BITS-1:0]      slot_msg_q  [NUM_PORTS];
  logic [MSG_BITS-1:0]      slot_msg_d  [NUM_PORTS];
  logic [ADDRESS_BITS-1:0]  slot_addr_q [NUM_PORTS];
  logic [ADDRESS_BITS-1:0]  slot_addr_d [NUM_PORTS];
  logic [L2_WIDTH-1:0]      slot_data_q [NUM_PORTS];
  logic [L2_WIDTH-1:0]      slot_data_d [NUM_PORTS];
  logic [ID_BITS-1:0]       slot_dest_q [NUM_PORTS];
  logic [ID_BITS-1:0]       slot_dest_d [NUM_PORTS];

  logic [MSG_BITS-1:0]      out_msg_q,  out_msg_d;
  logic [ADDRESS_BITS-1:0]  out_addr_q, out_addr_d;
  logic [L2_WIDTH-1:0]      out_data_q, out_data_d;
  logic [ID_BITS-1:0]       out_dest_q, out_dest_d;
  logic [SRC_W-1:0]         out_port_q, out_port_d;

  logic                     xfer;
  logic                     out_free;
  logic                     grant_vld;
  logic [SRC_W-1:0]         grant_idx;

  // Output stage is free when idle or when the packetizer takes the current message
  assign xfer     = (state_q == PRESENT) && !bus.packetizer_busy;
  assign out_free = (state_q == EMPTY) || xfer;

  // Round-robin: first full slot starting just after the last granted port
  always_comb begin
    int               cand;
    logic [SRC_W-1:0] cand_idx;
    cand      = 0;
    cand_idx  = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = int'(last_grant_q) + 1 + i;
      if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
      cand_idx = SRC_W'(cand);
      if (!grant_vld && slot_full_q[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  // Output FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (|slot_full_q) state_d = PRESENT;
      PRESENT: if (xfer && !(|slot_full_q)) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Slot capture and grant transfer. A slot is captured only while empty and
  // granted only while full, so both never touch the same slot in one cycle.
  always_comb begin
    slot_full_d  = slot_full_q;
    slot_msg_d   = slot_msg_q;
    slot_addr_d  = slot_addr_q;
    slot_data_d  = slot_data_q;
    slot_dest_d  = slot_dest_q;
    last_grant_d = last_grant_q;
    out_msg_d    = out_msg_q;
    out_addr_d   = out_addr_q;
    out_data_d   = out_data_q;
    out_dest_d   = out_dest_q;
    out_port_d   = out_port_q;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if ((bus.src_msg[k*MSG_BITS +: MSG_BITS] != '0) && !slot_full_q[k]) begin
        slot_full_d[k] = 1'b1;
        slot_msg_d[k]  = bus.src_msg[k*MSG_BITS +: MSG_BITS];
        slot_addr_d[k] = bus.src_address[k*ADDRESS_BITS +: ADDRESS_BITS];
        slot_data_d[k] = bus.src_data[k*L2_WIDTH +: L2_WIDTH];
        slot_dest_d[k] = bus.src_dest_id[k*ID_BITS +: ID_BITS];
      end
    end
    if (out_free && grant_vld) begin
      out_msg_d              = slot_msg_q[grant_idx];
      out_addr_d             = slot_addr_q[grant_idx];
      out_data_d             = slot_data_q[grant_idx];
      out_dest_d             = slot_dest_q[grant_idx];
      out_port_d             = grant_idx;
      slot_full_d[grant_idx] = 1'b0;
      last_grant_d           = grant_idx;
    end
  end

  // Control registers (reset)
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= EMPTY;
      slot_full_q  <= '0;
      last_grant_q <= SRC_W'(NUM_PORTS - 1);
    end else begin
      state_q      <= state_d;
      slot_full_q  <= slot_full_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Data registers (no reset; qualified by slot_full_q / state_q)
  always_ff @(posedge clock) begin
    slot_msg_q  <= slot_msg_d;
    slot_addr_q <= slot_addr_d;
    slot_data_q <= slot_data_d;
    slot_dest_q <= slot_dest_d;
    out_msg_q   <= out_msg_d;
    out_addr_q  <= out_addr_d;
    out_data_q  <= out_data_d;
    out_dest_q  <= out_dest_d;
    out_port_q  <= out_port_d;
  end

  // Outputs read as zero whenever nothing is presented
  assign bus.src_busy        = slot_full_q;
  assign bus.noc_msg_out     = (state_q == PRESENT) ? out_msg_q  : '0;
  assign bus.noc_address_out = (state_q == PRESENT) ? out_addr_q : '0;
  assign bus.noc_data_out    = (state_q == PRESENT) ? out_data_q : '0;
  assign bus.noc_dest_id     = (state_q == PRESENT) ? out_dest_q : '0;
  assign bus.noc_src_port    = (state_q == PRESENT) ? out_port_q : '0;

`ifdef NOC_ARB_OVF_CHECK_EN
  logic [NUM_PORTS-1:0] ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if ((bus.src_msg[k*MSG_BITS +: MSG_BITS] != '0) && slot_full_q[k]) ovf_d[k] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) ovf_q <= '0;
    else        ovf_q <= ovf_d;
  end

  assign ovf_error = ovf_q;
`endif
endmodule

// File: tb/tb_noc_out_arbiter.sv
// Randomized and directed bench for noc_out_arbiter, checked against a
// transaction-level reference model (slots, presented item, round-robin pointer).
module tb_noc_out_arbiter;
  localparam int NP = 3;
  localparam int MB = 4;
  localparam int AB = 32;
  localparam int LW = 128;
  localparam int IB = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  noc_out_arbiter_if #(.NUM_PORTS(NP), .MSG_BITS(MB), .ADDRESS_BITS(AB),
                       .L2_WIDTH(LW), .ID_BITS(IB)) bus ();
`ifdef NOC_ARB_OVF_CHECK_EN
  logic [NP-1:0] ovf_error;
`endif

  noc_out_arbiter #(.NUM_PORTS(NP), .MSG_BITS(MB), .ADDRESS_BITS(AB),
                    .L2_WIDTH(LW), .ID_BITS(IB)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
`ifdef NOC_ARB_OVF_CHECK_EN
    ,
    .ovf_error(ovf_error)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: one item per port slot, one presented item, rr pointer
  typedef struct {
    bit            full;
    logic [MB-1:0] msg;
    logic [AB-1:0] addr;
    logic [LW-1:0] data;
    logic [IB-1:0] dest;
    int            src;
  } item_t;

  item_t         m_slot [NP];
  item_t         m_out;
  int            m_last;
  logic [NP-1:0] m_ovf;

  task automatic model_advance();
    bit cap [NP];
    bit found;
    if (!reset) begin
      for (int k = 0; k < NP; k++) m_slot[k].full = 0;
      m_out.full = 0;
      m_last = NP - 1;
      m_ovf = '0;
      return;
    end
    for (int k = 0; k < NP; k++) begin
      cap[k] = (bus.src_msg[k*MB +: MB] != '0) && !m_slot[k].full;
      if ((bus.src_msg[k*MB +: MB] != '0) && m_slot[k].full) m_ovf[k] = 1'b1;
    end
    if (!m_out.full || !bus.packetizer_busy) begin
      m_out.full = 0;
      found = 0;
      for (int i = 1; i <= NP; i++) begin
        int c;
        c = (m_last + i) % NP;
        if (!found && m_slot[c].full) begin
          m_out = m_slot[c];
          m_last = c;
          m_slot[c].full = 0;
          found = 1;
        end
      end
    end
    for (int k = 0; k < NP; k++) begin
      if (cap[k]) begin
        m_slot[k].full = 1;
        m_slot[k].msg  = bus.src_msg[k*MB +: MB];
        m_slot[k].addr = bus.src_address[k*AB +: AB];
        m_slot[k].data = bus.src_data[k*LW +: LW];
        m_slot[k].dest = bus.src_dest_id[k*IB +: IB];
        m_slot[k].src  = k;
      end
    end
  endtask

  task automatic compare_all();
    logic [NP-1:0] eb;
    for (int k = 0; k < NP; k++) eb[k] = m_slot[k].full;
    chk("src_busy", 128'(bus.src_busy), 128'(eb));
    chk("noc_msg",  128'(bus.noc_msg_out),     m_out.full ? 128'(m_out.msg)  : 128'(0));
    chk("noc_addr", 128'(bus.noc_address_out), m_out.full ? 128'(m_out.addr) : 128'(0));
    chk("noc_data", 128'(bus.noc_data_out),    m_out.full ? 128'(m_out.data) : 128'(0));
    chk("noc_dest", 128'(bus.noc_dest_id),     m_out.full ? 128'(m_out.dest) : 128'(0));
    chk("noc_port", 128'(bus.noc_src_port),    m_out.full ? 128'(m_out.src)  : 128'(0));
`ifdef NOC_ARB_OVF_CHECK_EN
    chk("ovf_error", 128'(ovf_error), 128'(m_ovf));
`endif
  endtask

  task automatic tick();
    model_advance();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic clear_src();
    bus.src_msg     = '0;
    bus.src_address = '0;
    bus.src_data    = '0;
    bus.src_dest_id = '0;
  endtask

  task automatic send(input int k, input logic [MB-1:0] msg, input logic [AB-1:0] addr,
                      input logic [IB-1:0] dest);
    bus.src_msg[k*MB +: MB]     = msg;
    bus.src_address[k*AB +: AB] = addr;
    bus.src_data[k*LW +: LW]    = {$urandom, $urandom, $urandom, $urandom};
    bus.src_dest_id[k*IB +: IB] = dest;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_src();
    bus.packetizer_busy = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int order [$];
    int n;
    clear_src();
    bus.packetizer_busy = 1'b0;
    m_last = NP - 1;
    m_out.full = 0;
    m_ovf = '0;
    for (int k = 0; k < NP; k++) m_slot[k].full = 0;

    // Reset state
    do_reset();
    chk("rst_msg",  128'(bus.noc_msg_out), 128'(0));
    chk("rst_busy", 128'(bus.src_busy), 128'(0));
    chk("rst_port", 128'(bus.noc_src_port), 128'(0));

    // Single message, 2-cycle latency
    send(0, 4'h3, 32'h3fffffc0, 2'd1);
    tick();
    chk("lat_busy_t1", 128'(bus.src_busy), 128'(3'b001));
    chk("lat_msg_t1",  128'(bus.noc_msg_out), 128'(0));
    clear_src();
    tick();
    chk("lat_msg_t2",  128'(bus.noc_msg_out), 128'(4'h3));
    chk("lat_addr_t2", 128'(bus.noc_address_out), 128'(32'h3fffffc0));
    chk("lat_port_t2", 128'(bus.noc_src_port), 128'(0));
    chk("lat_busy_t2", 128'(bus.src_busy), 128'(0));
    tick();
    chk("lat_msg_t3",  128'(bus.noc_msg_out), 128'(0));

    // Two simultaneous senders, back-to-back
    do_reset();
    send(0, 4'h1, 32'h100, 2'd0);
    send(1, 4'h2, 32'h200, 2'd2);
    tick();
    clear_src();
    tick();
    chk("b2b_first",  128'(bus.noc_address_out), 128'(32'h100));
    tick();
    chk("b2b_second", 128'(bus.noc_address_out), 128'(32'h200));
    chk("b2b_port",   128'(bus.noc_src_port), 128'(1));

    // Packetizer backpressure for 4 presented cycles
    do_reset();
    send(0, 4'h1, 32'h100, 2'd0);
    send(1, 4'h2, 32'h200, 2'd2);
    tick();
    clear_src();
    bus.packetizer_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_frozen", 128'(bus.noc_address_out), 128'(32'h100));
    end
    tick();
    bus.packetizer_busy = 1'b0;
    chk("bp_xfer_cycle", 128'(bus.noc_address_out), 128'(32'h100));
    tick();
    chk("bp_next", 128'(bus.noc_address_out), 128'(32'h200));
    tick();

    // Saturated round-robin
    do_reset();
    for (int k = 0; k < NP; k++) send(k, 4'h5, 32'(k * 32'h1000), 2'(k));
    n = 0;
    while (order.size() < 6 && n < 30) begin
      tick();
      n++;
      if (bus.noc_msg_out != '0) order.push_back(int'(bus.noc_src_port));
    end
    chk("rr_count", 128'(order.size()), 128'(6));
    for (int i = 0; i < order.size(); i++) chk("rr_order", 128'(order[i]), 128'(i % NP));
    clear_src();

    // Send while busy is ignored
    do_reset();
    send(0, 4'h1, 32'h100, 2'd0);
    send(1, 4'h2, 32'h250, 2'd2);
    bus.packetizer_busy = 1'b1;
    tick();
    clear_src();
    tick();
    chk("ovr_busy1", 128'(bus.src_busy[1]), 128'(1));
    send(1, 4'h6, 32'h300, 2'd3);
    tick();
    clear_src();
    bus.packetizer_busy = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(bus.noc_msg_out != '0 && bus.noc_src_port == 2'd1) && n < 10);
    chk("ovr_found", 128'(n < 10), 128'(1));
    chk("ovr_addr",  128'(bus.noc_address_out), 128'(32'h250));
    chk("ovr_msg",   128'(bus.noc_msg_out), 128'(4'h2));
`ifdef NOC_ARB_OVF_CHECK_EN
    tick();
    tick();
    chk("ovr_sticky", 128'(ovf_error[1]), 128'(1));
`endif

    // Reset mid-transfer
    do_reset();
    send(1, 4'h7, 32'h700, 2'd1);
    send(2, 4'h8, 32'h800, 2'd2);
    bus.packetizer_busy = 1'b1;
    tick();
    clear_src();
    tick();
    chk("rmid_port", 128'(bus.noc_src_port), 128'(1));
    reset = 1'b0;
    send(0, 4'h9, 32'h900, 2'd0);
    tick();
    chk("rmid_msg",  128'(bus.noc_msg_out), 128'(0));
    chk("rmid_busy", 128'(bus.src_busy), 128'(0));
    reset = 1'b1;
    clear_src();
    bus.packetizer_busy = 1'b0;
    tick();
    chk("rmid_drop", 128'(bus.noc_msg_out), 128'(0));
    for (int k = 0; k < NP; k++) send(k, 4'h4, 32'(32'hA00 + k), 2'(k));
    tick();
    clear_src();
    tick();
    chk("rmid_first", 128'(bus.noc_src_port), 128'(0));
    chk("rmid_fmsg",  128'(bus.noc_msg_out), 128'(4'h4));

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 99) != 0);
      for (int k = 0; k < NP; k++) begin
        if ($urandom_range(0, 1) == 1)
          send(k, 4'($urandom_range(0, 15)), $urandom, 2'($urandom_range(0, 3)));
        else
          bus.src_msg[k*MB +: MB] = '0;
      end
      bus.packetizer_busy = ($urandom_range(0, 9) < 3);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
